// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write scoreboard (x0 hardwired to zero).
// Latency: reads, rbusy and dbg_data are combinational; writes, reservations and busy_cnt update on the clk edge.
// Backpressure: none; the hazard unit stalls decode using rbusy.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset (clears all state)
//   raddr/rdata/rbusy     NRP packed read ports: address, data, outstanding-reservation flag
//   we/waddr/wdata        writeback port; a write also clears the target's reservation
//   rsv_valid/rsv_addr    decode reserves rd as pending-write
//   flush                 drops every reservation; a same-edge write still lands
//   busy_cnt              registered count of reserved registers
//   dbg_addr/dbg_data     debug read port, always from stored state
//
// Optional: define REGFILE_BYPASS_EN for write-to-read forwarding on the read ports.
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRP   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush,
  output logic [AW:0]         busy_cnt,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  // Storage spans the full address space so any address indexes safely;
  // entries 0 and >= NREGS are never written and stay at their reset value of 0.
  localparam int DEPTH = 1 << AW;

  logic [XLEN-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             wr_ok;
  logic             rsv_ok;

  function automatic logic valid_idx(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  assign wr_ok  = we && valid_idx(waddr);
  assign rsv_ok = rsv_valid && valid_idx(rsv_addr) && !flush;

  // Reservation is applied after the writeback clear so a new producer
  // wins over a same-edge writeback to the same register.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_ok)  busy_nxt[waddr]    = 1'b0;
      if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // rdata is the two's-complement register value; no sign handling is needed here.
  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst_n so the ports read zero throughout reset.
    logic hit;
    assign hit = rst_n && wr_ok && (ra == waddr);
    assign rdata[i*XLEN +: XLEN] = hit ? wdata : regs[ra];
    assign rbusy[i] = hit ? (rsv_valid && (rsv_addr == waddr)) : busy[ra];
`else
    assign rdata[i*XLEN +: XLEN] = regs[ra];
    assign rbusy[i] = busy[ra];
`endif
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed test of regfile_scoreboard: reset, read/write, x0, scoreboard priority, flush, dual/debug ports, NREGS=24 build.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 2 time units after it.
// Backpressure: not applicable.
module tb_regfile_scoreboard;
  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NRP  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  logic [XLEN-1:0]     rdata24;
  logic                rbusy24;
  logic [AW:0]         busy_cnt24;
  logic [XLEN-1:0]     dbg_data24;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(32), .AW(AW), .NRP(NRP)) u_dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .flush(flush), .busy_cnt(busy_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(24), .AW(AW), .NRP(1)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr[AW-1:0]), .rdata(rdata24), .rbusy(rbusy24),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .flush(flush), .busy_cnt(busy_cnt24), .dbg_addr(dbg_addr), .dbg_data(dbg_data24)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: commands driven before the call act at this edge, then drop to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    we        = 1'b0;
    rsv_valid = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_valid = 1'b1; rsv_addr = a;
  endtask

  initial begin
    rst_n = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
    rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0; dbg_addr = '0;

    // Reset held with write and reservation attempts.
    #2;
    wr(5'd5, 64'd99); rsv(5'd3); set_rd(5'd5, 5'd3); dbg_addr = 5'd5;
    repeat (2) @(posedge clk);
    #2;
    check("rst_rdata0", rdata[63:0], 64'd0);
    check("rst_rbusy", {62'd0, rbusy}, 64'd0);
    check("rst_busy_cnt", {58'd0, busy_cnt}, 64'd0);
    check("rst_dbg", dbg_data, 64'd0);
    we = 1'b0; rsv_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Write -7 to x5; same-cycle read shows old value unless forwarding.
    wr(5'd5, -64'sd7); set_rd(5'd5, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_rd5", rdata[63:0], 64'hFFFF_FFFF_FFFF_FFF9);
`else
    check("same_cycle_rd5", rdata[63:0], 64'd0);
`endif
    cyc();
    check("rd5_after", rdata[63:0], 64'hFFFF_FFFF_FFFF_FFF9);

    // x0 protection.
    wr(5'd0, 64'd123); set_rd(5'd0, 5'd0);
    cyc();
    check("x0_read", rdata[63:0], 64'd0);
    rsv(5'd0);
    cyc();
    check("x0_rsv_cnt", {58'd0, busy_cnt}, 64'd0);
    check("x0_rbusy", {63'd0, rbusy[0]}, 64'd0);

    // Scoreboard: reserve 3 then 7.
    rsv(5'd3); cyc();
    rsv(5'd7); cyc();
    set_rd(5'd3, 5'd7);
    #1;
    check("sb_cnt2", {58'd0, busy_cnt}, 64'd2);
    check("sb_rbusy37", {62'd0, rbusy}, 64'd3);
    wr(5'd3, 64'd33); cyc();
    check("sb_wr3_cnt", {58'd0, busy_cnt}, 64'd1);
    check("sb_wr3_rbusy", {62'd0, rbusy}, 64'd2);
    check("sb_wr3_data", rdata[63:0], 64'd33);
    wr(5'd7, 64'd77); rsv(5'd7); cyc();
    check("sb_wr_rsv7_cnt", {58'd0, busy_cnt}, 64'd1);
    check("sb_wr_rsv7_rbusy", {63'd0, rbusy[1]}, 64'd1);
    check("sb_wr_rsv7_data", rdata[127:64], 64'd77);
    rsv(5'd7); cyc();
    check("sb_rersv_cnt", {58'd0, busy_cnt}, 64'd1);

    // Flush with 4 reserved, plus same-edge reservation of 9 and write of 12.
    rsv(5'd1); cyc();
    rsv(5'd2); cyc();
    rsv(5'd4); cyc();
    check("fl_pre_cnt", {58'd0, busy_cnt}, 64'd4);
    flush = 1'b1; rsv(5'd9); wr(5'd12, 64'd1212); set_rd(5'd9, 5'd12);
    cyc();
    check("fl_cnt", {58'd0, busy_cnt}, 64'd0);
    check("fl_rbusy", {62'd0, rbusy}, 64'd0);
    check("fl_wr12", rdata[127:64], 64'd1212);

    // Dual port and debug read.
    wr(5'd10, 64'd42); cyc();
    set_rd(5'd10, 5'd10); dbg_addr = 5'd10;
    #1;
    check("dual_p0", rdata[63:0], 64'd42);
    check("dual_p1", rdata[127:64], 64'd42);
    check("dbg10", dbg_data, 64'd42);
    wr(5'd10, 64'd43);
    #1;
    check("dbg_no_bypass", dbg_data, 64'd42);
    cyc();
    check("dbg10_new", dbg_data, 64'd43);

    // NREGS=24 instance: 30 is out of range, 23 is the last valid register.
    wr(5'd30, 64'd555); rsv(5'd30); cyc();
    set_rd(5'd30, 5'd0); dbg_addr = 5'd30;
    #1;
    check("n24_rd30", rdata24, 64'd0);
    check("n24_dbg30", dbg_data24, 64'd0);
    check("n24_cnt", {58'd0, busy_cnt24}, 64'd0);
    check("n32_rd30", rdata[63:0], 64'd555);
    check("n32_rbusy30", {63'd0, rbusy[0]}, 64'd1);
    wr(5'd23, 64'd2323); rsv(5'd23); cyc();
    set_rd(5'd23, 5'd0);
    #1;
    check("n24_rd23", rdata24, 64'd2323);
    check("n24_rbusy23", {63'd0, rbusy24}, 64'd1);

    // Asynchronous reset mid-cycle clears contents without a clock edge.
    set_rd(5'd10, 5'd30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_rd10", rdata[63:0], 64'd0);
    check("arst_rbusy", {62'd0, rbusy}, 64'd0);
    check("arst_cnt", {58'd0, busy_cnt}, 64'd0);
    check("arst_n24_cnt", {58'd0, busy_cnt24}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file for the pipelined core.
- One synchronous write port, NRP asynchronous read ports, and a hardwired-zero x0.
- Adds a per-register busy scoreboard: decode reserves rd at issue, and writeback clears the reservation. The hazard unit uses this to stall.
- Sits between Instruction_Decode (read/reserve) and Writeback (write). It replaces the unclocked register array.

Parameters:
XLEN, 64, data width in bits
NREGS, 32, number of architectural registers (2..32); index 0 is hardwired zero
AW, 5, register address width; must satisfy 2**AW >= NREGS
NRP, 2, number of read ports (1..4)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
raddr  input  NRP*AW  read addresses; port i at [i*AW +: AW]
rdata  output  NRP*XLEN  read data; port i at [i*XLEN +: XLEN], signed value
rbusy  output  NRP  port i register has an outstanding reservation
we  input  1  write enable (RegWrite)
waddr  input  AW  write address (rd)
wdata  input  XLEN  write data
rsv_valid  input  1  reserve rsv_addr as pending-write at this edge
rsv_addr  input  AW  register being reserved
flush  input  1  clear all reservations (pipeline flush)
busy_cnt  output  AW+1  number of registers currently reserved
dbg_addr  input  AW  waveform/debug read address
dbg_data  output  XLEN  contents of dbg_addr (no bypass)

Behaviour:
Reset:
- Reset is asynchronous and active-low: clk is the only clock, and rst_n asserted low immediately clears all state.
- While rst_n=0, all registers are 0, all busy bits are 0, and busy_cnt=0.
- Consequently rdata=0, rbusy=0 and dbg_data=0 while in reset.
- Deassertion takes effect synchronously at the next clk edge.

Reads:
- Reads are combinational (zero latency).
- rdata[i] = reg[raddr[i]].
- raddr=0 or raddr>=NREGS returns 0; the matching rbusy bit is 0.

Writes:
- On the rising edge with we=1, reg[waddr] <= wdata.
- Ignored when waddr=0 or waddr>=NREGS.
- New value is visible on rdata from the following cycle (unless bypass is enabled; see below).

Scoreboard, per register r (r != 0), next busy[r] by priority:
1. flush=1 -> 0 for all r. rsv_valid is ignored; the write still proceeds.
2. rsv_valid=1 && rsv_addr=r -> 1 (a new producer wins over a same-edge writeback to r).
3. we=1 && waddr=r -> 0.
4. otherwise hold.
- Reservations of 0 or of addresses >=NREGS are ignored.
- Re-reserving a register that is already busy leaves it busy. There is no nesting count.
- busy_cnt is a registered counter equal to popcount(busy), updated at the same edge as busy. Range 0..NREGS-1.

Other outputs:
- rbusy[i] = busy[raddr[i]].
- dbg_data = reg[dbg_addr] with the same zero/out-of-range rules as the read ports. It is never bypassed.

Simultaneous read and write of the same register without bypass: rdata returns the old value.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding on each port. If we=1, waddr!=0, waddr<NREGS and raddr[i]=waddr:
  - rdata[i] = wdata in the same cycle.
  - rbusy[i] = 0, unless rsv_valid=1 and rsv_addr=waddr in the same cycle, in which case rbusy[i] = 1.
- Undefined: no forwarding; rdata and rbusy come purely from stored state.

Test Plan:
- Reset: hold rst_n=0 with preloaded writes attempted -> all rdata=0, busy_cnt=0; drop rst_n mid-run after writes -> rdata returns to 0 immediately, with no clock needed.
- Write then read: we=1, waddr=5, wdata=-7 at edge N; raddr0=5 -> rdata0=-7 (0xFFFF_FFFF_FFFF_FFF9) from cycle N+1. Same cycle: old value 0 without bypass; -7 with REGFILE_BYPASS_EN.
- x0 protection: we=1, waddr=0, wdata=123 -> raddr0=0 reads 0; rsv_addr=0 -> busy_cnt stays 0.
- Scoreboard: reserve 3, then 7 -> busy_cnt=2 and rbusy set for 3 and 7. Write 3 -> busy_cnt=1. Same-edge write 7 plus rsv 7 -> 7 stays busy, busy_cnt=1.
- Flush: 4 registers reserved, flush=1 with rsv_valid=1, rsv_addr=9, and we to 12 -> busy_cnt=0, reg 9 not busy, reg12 written.
- Dual port and debug: raddr0=raddr1=10 after writing 42 -> both ports read 42; dbg_addr=10 -> dbg_data=42. NREGS=24 build: write to 30 ignored, read of 30 returns 0.
